// File: rtl/uart_model_pkg.sv
// Shared types and helpers for the bench-side UART models (transmitter and receiver).
// Contents:
//   uart_state_e - frame FSM states
//   uart_cfg_t   - clamped frame configuration {baud, bits, stops}
//   clamp_cfg()  - maps raw control inputs onto the legal frame configuration
package uart_model_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

  localparam int unsigned UART_MIN_BITS  = 5;
  localparam int unsigned UART_MAX_BITS  = 8;
  localparam int unsigned UART_MAX_STOPS = 2;

  typedef struct packed {
    logic [15:0] baud;
    logic [3:0]  bits;
    logic [1:0]  stops;
  } uart_cfg_t;

  // baud 0 -> 1; bits clamped to 5..8; stops 0 -> 1, above 2 -> 2
  function automatic uart_cfg_t clamp_cfg(input logic [15:0] baud,
                                          input logic [3:0]  bits,
                                          input logic [1:0]  stops);
    uart_cfg_t c;
    c.baud = (baud == '0) ? 16'd1 : baud;
    if (bits < 4'(UART_MIN_BITS))      c.bits = 4'(UART_MIN_BITS);
    else if (bits > 4'(UART_MAX_BITS)) c.bits = 4'(UART_MAX_BITS);
    else                               c.bits = bits;
    if (stops == '0)                        c.stops = 2'd1;
    else if (stops > 2'(UART_MAX_STOPS))    c.stops = 2'(UART_MAX_STOPS);
    else                                    c.stops = stops;
    return c;
  endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous FIFO used by the UART models to queue bytes.
// Ports:
//   clk, rst_n  - clock (rising edge), asynchronous active-low reset
//   push_i      - write wdata_i (ignored while full)
//   wdata_i     - write data
//   pop_i       - advance read pointer (ignored while empty)
//   rdata_o     - head entry, valid whenever empty_o is low
//   full_o      - level == DEPTH
//   empty_o     - level == 0
//   level_o     - number of entries held
module uart_byte_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;

  // Pointers wrap naturally; the level is kept as its own up/down count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      level_q <= level_q + 1'b1;
      else if (!do_push && do_pop) level_q <= level_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx_model.sv
// Bench-side UART transmitter: queues bytes and serialises them onto txd.
// Ports:
//   clk, rst_n      - clock (rising edge), asynchronous active-low reset
//   ctrl_baud_clks  - clk cycles per bit (0 behaves as 1)
//   ctrl_bits       - data bits per frame (clamped 5..8)
//   ctrl_stops      - stop bits (0 -> 1, >=2 -> 2)
//   tx_valid/tx_ready/tx_data - byte push handshake
//   txd             - serial line, idle high
//   tx_busy         - frame in flight or bytes queued
//   tx_done         - one-cycle pulse as each frame completes
//   fifo_level      - queued bytes, excluding the frame in flight
module uart_tx_model
  import uart_model_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DATA_W     = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [15:0]                   ctrl_baud_clks,
  input  logic [3:0]                    ctrl_bits,
  input  logic [1:0]                    ctrl_stops,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  input  logic [DATA_W-1:0]             tx_data,
  output logic                          txd,
  output logic                          tx_busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  uart_state_e        state_q, state_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [3:0]         bit_idx_q, bit_idx_d;
  logic [1:0]         stop_cnt_q, stop_cnt_d;
  logic [DATA_W-1:0]  shreg_q, shreg_d;
  uart_cfg_t          cfg_q, cfg_d;
  uart_cfg_t          cfg_new;
  logic               txd_q, txd_d;
  logic               done_q, done_d;
  logic               load;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [DATA_W-1:0]  fifo_rdata;

  uart_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (tx_valid),
    .wdata_i (tx_data),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign tx_ready = !fifo_full;
  assign tx_busy  = (state_q != IDLE) || !fifo_empty;
  assign txd      = txd_q;
  assign tx_done  = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      stop_cnt_q <= '0;
      shreg_q    <= '0;
      cfg_q      <= '0;
      txd_q      <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      stop_cnt_q <= stop_cnt_d;
      shreg_q    <= shreg_d;
      cfg_q      <= cfg_d;
      txd_q      <= txd_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    stop_cnt_d = stop_cnt_q;
    shreg_d    = shreg_q;
    cfg_d      = cfg_q;
    txd_d      = txd_q;
    done_d     = 1'b0;
    load       = 1'b0;
    fifo_pop   = 1'b0;
    cfg_new    = clamp_cfg(ctrl_baud_clks, ctrl_bits, ctrl_stops);

    unique case (state_q)
      IDLE: begin
        txd_d = 1'b1;
        load  = !fifo_empty;
      end
      START: begin
        if (cnt_q == '0) begin
          state_d   = DATA;
          cnt_d     = cfg_q.baud - 16'd1;
          bit_idx_d = '0;
          txd_d     = shreg_q[0];
          shreg_d   = shreg_q >> 1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          cnt_d = cfg_q.baud - 16'd1;
          if (bit_idx_q == cfg_q.bits - 4'd1) begin
            state_d    = STOP;
            stop_cnt_d = cfg_q.stops - 2'd1;
            txd_d      = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
            txd_d     = shreg_q[0];
            shreg_d   = shreg_q >> 1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      STOP: begin
        if (cnt_q == '0) begin
          if (stop_cnt_q == '0) begin
            done_d  = 1'b1;
            state_d = IDLE;
            txd_d   = 1'b1;
            load    = !fifo_empty;
          end else begin
            stop_cnt_d = stop_cnt_q - 2'd1;
            cnt_d      = cfg_q.baud - 16'd1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Frame start is shared by IDLE and the last STOP cycle so queued bytes
    // go out back-to-back; config is sampled only here.
    if (load) begin
      fifo_pop = 1'b1;
      cfg_d    = cfg_new;
      shreg_d  = fifo_rdata;
      state_d  = START;
      txd_d    = 1'b0;
      cnt_d    = cfg_new.baud - 16'd1;
    end
  end

endmodule

// File: tb/tb_uart_tx_model.sv
// Self-checking bench for uart_tx_model: the expected line waveform is built
// frame by frame from the byte/config sequence and compared to the recorded txd.
module tb_uart_tx_model;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] baud;
  logic [3:0]  bits;
  logic [1:0]  stops;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  tx_data;
  logic        txd;
  logic        tx_busy;
  logic        tx_done;
  logic [4:0]  fifo_level;

  int checks = 0;
  int errors = 0;

  bit   rec_en = 1'b0;
  logic rec_txd[$];
  logic rec_done[$];
  bit   exp_txd[$];
  bit   exp_done[$];
  bit   pend_done;
  bit   saw_full;

  always #5 clk = ~clk;

  uart_tx_model #(
    .FIFO_DEPTH (16),
    .DATA_W     (8)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ctrl_baud_clks (baud),
    .ctrl_bits      (bits),
    .ctrl_stops     (stops),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .tx_data        (tx_data),
    .txd            (txd),
    .tx_busy        (tx_busy),
    .tx_done        (tx_done),
    .fifo_level     (fifo_level)
  );

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rec_en) begin
      rec_txd.push_back(txd);
      rec_done.push_back(tx_done);
    end
  endtask

  // Reference line model
  task automatic push_exp(input bit v);
    exp_txd.push_back(v);
    exp_done.push_back(pend_done);
    pend_done = 1'b0;
  endtask

  task automatic new_stream();
    rec_txd.delete();
    rec_done.delete();
    exp_txd.delete();
    exp_done.delete();
    pend_done = 1'b0;
    rec_en    = 1'b1;
    push_exp(1'b1);   // sample right after the push edge: still idle
  endtask

  task automatic add_frame(input logic [7:0] b, input int unsigned rb,
                           input int unsigned rn, input int unsigned rs);
    int unsigned bb, n, s;
    bb = (rb == 0) ? 1 : rb;
    n  = (rn < 5) ? 5 : ((rn > 8) ? 8 : rn);
    s  = (rs == 0) ? 1 : ((rs > 2) ? 2 : rs);
    for (int unsigned k = 0; k < bb; k++) push_exp(1'b0);
    for (int unsigned i = 0; i < n; i++)
      for (int unsigned k = 0; k < bb; k++) push_exp(b[i]);
    for (int unsigned k = 0; k < s * bb; k++) push_exp(1'b1);
    pend_done = 1'b1;
  endtask

  task automatic compare_stream(input string name);
    int idx_t, idx_d;
    rec_en = 1'b0;
    check({name, "_len_ok"}, 32'(exp_txd.size() <= rec_txd.size()), 32'd1);
    while (exp_txd.size() < rec_txd.size()) push_exp(1'b1);
    idx_t = rec_txd.size() - 1;
    idx_d = rec_txd.size() - 1;
    for (int i = rec_txd.size() - 1; i >= 0; i--) begin
      if (rec_txd[i] !== exp_txd[i])   idx_t = i;
      if (rec_done[i] !== exp_done[i]) idx_d = i;
    end
    check($sformatf("%s_txd@%0d", name, idx_t), 32'(rec_txd[idx_t]), 32'(exp_txd[idx_t]));
    check($sformatf("%s_done@%0d", name, idx_d), 32'(rec_done[idx_d]), 32'(exp_done[idx_d]));
  endtask

  task automatic push_byte(input logic [7:0] b);
    int n;
    tx_valid = 1'b1;
    tx_data  = b;
    n = 0;
    while (!tx_ready && n < 5000) begin
      if (!saw_full) begin
        check("full_level", 32'(fifo_level), 32'd16);
        saw_full = 1'b1;
      end
      tick();
      n++;
    end
    if (n >= 5000) check("push_timeout", 32'(tx_ready), 32'd1);
    tick();
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit, input int extra);
    int n;
    n = 0;
    while (tx_busy && n < limit) begin
      tick();
      n++;
    end
    if (n >= limit) check("idle_timeout", 32'(tx_busy), 32'd0);
    repeat (extra) tick();
  endtask

  initial begin
    logic [7:0] b, b2, key;
    rst_n    = 1'b0;
    baud     = 16'd2;
    bits     = 4'd8;
    stops    = 2'd1;
    tx_valid = 1'b0;
    tx_data  = '0;
    saw_full = 1'b0;
    #12;
    check("reset_txd",   32'(txd),        32'd1);
    check("reset_ready", 32'(tx_ready),   32'd1);
    check("reset_busy",  32'(tx_busy),    32'd0);
    check("reset_done",  32'(tx_done),    32'd0);
    check("reset_level", 32'(fifo_level), 32'd0);
    #5 rst_n = 1'b1;
    tick();

    // Single byte A5, B=2 N=8 S=1
    new_stream();
    push_byte(8'hA5);
    add_frame(8'hA5, 2, 8, 1);
    check("single_busy", 32'(tx_busy), 32'd1);
    tick();
    check("single_start_txd", 32'(txd), 32'd0);
    wait_idle(100, 4);
    compare_stream("single_a5");

    // Back-to-back bytes
    new_stream();
    push_byte(8'h55);
    push_byte(8'h0F);
    add_frame(8'h55, 2, 8, 1);
    add_frame(8'h0F, 2, 8, 1);
    wait_idle(200, 4);
    compare_stream("b2b");

    // Clamps
    baud = 16'd0; bits = 4'd12; stops = 2'd0;
    b = 8'($urandom);
    new_stream();
    push_byte(b);
    add_frame(b, 0, 12, 0);
    wait_idle(100, 3);
    compare_stream("clamp_hi");
    baud = 16'd1; bits = 4'd3; stops = 2'd3;
    b = 8'($urandom);
    new_stream();
    push_byte(b);
    add_frame(b, 1, 3, 3);
    wait_idle(100, 3);
    compare_stream("clamp_lo");

    // Config change mid-frame
    baud = 16'd2; bits = 4'd8; stops = 2'd1;
    b  = 8'($urandom);
    b2 = 8'($urandom);
    new_stream();
    push_byte(b);
    add_frame(b, 2, 8, 1);
    repeat (6) tick();
    baud = 16'd4;
    push_byte(b2);
    add_frame(b2, 4, 8, 1);
    wait_idle(200, 3);
    compare_stream("cfg_change");

    // Reset mid-DATA with 3 bytes queued
    baud = 16'd4; bits = 4'd8; stops = 2'd1;
    for (int i = 0; i < 4; i++) push_byte(8'($urandom));
    repeat (12) tick();
    check("pre_reset_level", 32'(fifo_level), 32'd3);
    check("pre_reset_busy",  32'(tx_busy),    32'd1);
    rst_n = 1'b0;
    #2;
    check("mid_reset_txd",   32'(txd),        32'd1);
    check("mid_reset_level", 32'(fifo_level), 32'd0);
    check("mid_reset_ready", 32'(tx_ready),   32'd1);
    check("mid_reset_busy",  32'(tx_busy),    32'd0);
    check("mid_reset_done",  32'(tx_done),    32'd0);
    rst_n = 1'b1;
    new_stream();
    repeat (30) tick();
    compare_stream("post_reset_quiet");
    check("post_reset_busy", 32'(tx_busy), 32'd0);
    b = 8'($urandom);
    new_stream();
    push_byte(b);
    add_frame(b, 4, 8, 1);
    wait_idle(200, 3);
    compare_stream("post_reset_frame");

    // Fill FIFO behind a long frame
    baud = 16'd100; bits = 4'd8; stops = 2'd1;
    saw_full = 1'b0;
    new_stream();
    for (int i = 0; i < 18; i++) begin
      b = 8'($urandom);
      push_byte(b);
      add_frame(b, 100, 8, 1);
    end
    check("saw_full", 32'(saw_full), 32'd1);
    wait_idle(40000, 3);
    compare_stream("fill");

    // All 256 byte values under randomised frame configs
    key = 8'($urandom);
    for (int c = 0; c < 16; c++) begin
      int unsigned rb, rn, rs;
      rb = $urandom_range(0, 3);
      rn = $urandom_range(0, 15);
      rs = $urandom_range(0, 3);
      baud = 16'(rb); bits = 4'(rn); stops = 2'(rs);
      new_stream();
      for (int j = 0; j < 16; j++) begin
        b = 8'(c * 16 + j) ^ key;
        push_byte(b);
        add_frame(b, rb, rn, rs);
      end
      wait_idle(2000, 3);
      compare_stream($sformatf("sweep%0d", c));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
